uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
Parametrised successor to the existing fixed-8N1 UART receiver. It adds a runtime baud divisor, 16x oversampling with 3-sample majority vote, glitch-rejecting start detection and configurable data width. It also supports runtime parity and stop-bit modes, framing/parity/overrun error reporting, and a valid/ready output holding register. It sits between the pad-level rx_in and the byte-consumer logic (FIFO or register block).

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first on the line
DIV_W, 16, width of runtime oversample divisor
OS_RATE, 16, oversample ticks per bit (fixed 16; majority samples at 7,8,9)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
rx_in  input  1  asynchronous serial line, idle high
cfg_div  input  DIV_W  clk cycles per oversample tick; 0 treated as 1
cfg_parity  input  2  0=none, 1=even, 2=odd, 3=none
cfg_stop2  input  1  1 = two stop bits checked
rx_data  output  DATA_W  received word
rx_valid  output  1  rx_data/err flags valid; held until accepted
rx_ready  input  1  consumer accept; transfer when rx_valid && rx_ready
err_frame  output  1  stop bit sampled 0; qualified by rx_valid
err_parity  output  1  parity mismatch; qualified by rx_valid
err_overrun  output  1  one-cycle pulse: completed frame dropped
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: rx_data=0, rx_valid=0, err_*=0, busy=0, state=IDLE. Both sync flops and the line sample reset to 1.
- rx_in passes through a 2-flop synchroniser (rx_s); no other logic sees rx_in.
- Tick generator: down-counter reloads max(cfg_div,1)-1 and emits a 1-cycle tick at 0. It free-runs in IDLE and is re-phased to reload on start detection.
- Config (cfg_div, cfg_parity, cfg_stop2) is latched at start detection; mid-frame changes affect only the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: rx_s==0 -> START, tick count cleared.
  - START: at tick 9, majority(7,8,9). If 1, it is a glitch -> IDLE with no output. If 0 -> DATA.
  - DATA: DATA_W bits of 16 ticks each, majority at 7,8,9, shifted in LSB first. Then -> PARITY if parity enabled, else STOP.
  - PARITY: one bit. err_parity = (XOR of data ^ parity bit) != (odd mode).
  - STOP: 1 or 2 bits. Any stop majority 0 sets err_frame. The frame completes at tick 9 of the last stop bit, so the receiver re-arms half a bit early.
  - On completion: if err_frame -> WAIT_IDLE, else -> IDLE.
  - WAIT_IDLE: stays until rx_s==1, to prevent retrigger on a held-low line; then -> IDLE.
- Delivery: on the cycle after the completing tick, rx_data/err_frame/err_parity load and rx_valid=1, provided the holding register is empty or being accepted that same cycle. Simultaneous accept and load gives the new word, with rx_valid staying 1.
- Overrun: if rx_valid && !rx_ready at completion, the new frame is discarded, the old word is kept and err_overrun pulses 1 cycle.
- Latency from the line: 2 sync cycles, plus the frame time to mid last-stop bit, plus 1 cycle.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
UART_RX_BREAK_DET_EN: adds output brk_det (1 bit, reset 0).
- With the macro: a frame with all data bits 0, parity 0 (if enabled) and stop 0 is not delivered. brk_det pulses 1 cycle instead, and the FSM enters WAIT_IDLE.
- Without the macro: the port is absent, and such a frame is delivered as rx_data=0 with err_frame=1.

Decomposition:
- Package uart_pkg: parity enum (PAR_NONE, PAR_EVEN, PAR_ODD), FSM state enum, constants OS_RATE=16, SAMPLE_MID=8.
- Sub-module uart_baud_tick: divisor counter with re-phase input and tick output. It is reusable by a future transmitter.

Test Plan:
- cfg_div=4, 8N1, send 0xA5 -> rx_valid rises with rx_data=0xA5, err_frame=0, err_parity=0; rx_ready held 1 clears it next cycle.
- cfg_parity=1 (even), send 0x07 with parity bit 0 -> rx_data=0x07, err_parity=1; repeat with parity bit 1 -> err_parity=0.
- Low glitch of 2 ticks on idle line -> no rx_valid; the next valid frame 0x3C is received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and err_overrun pulses once after the second frame.
- cfg_stop2=1, second stop bit driven 0 on frame 0x55 -> err_frame=1; the FSM does not re-arm until the line returns high.
- Assert rst_n low mid-DATA of 0xFF -> outputs go to reset values; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver
// and its baud tick generator.
package uart_pkg;

    localparam int OS_RATE    = 16;
    localparam int SAMPLE_MID = 8;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Receiver FSM encoding, kept as plain constants for legacy tooling.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_PARITY    = 3'd3;
    localparam state_t ST_STOP      = 3'd4;
    localparam state_t ST_WAIT_IDLE = 3'd5;

    // cfg_parity code 3 is reserved and behaves as no parity.
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one-cycle tick every max(div,1)
// clocks; rephase restarts the period so the first tick lands one period later.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             rephase,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    // A divisor of 0 behaves as 1: reload 0 gives a tick every cycle.
    assign reload = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick   = (cnt == '0) && !rephase;

    // NOTE: sequential state is always assigned with <=, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rephase || cnt == '0) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with 3-sample majority vote,
// parity/stop checking and a valid/ready holding register.
// Define UART_RX_BREAK_DET_EN to add the brk_det break-detect output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DIV_W   = 16,
    parameter int OS_RATE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              err_frame,
    output logic              err_parity,
    output logic              err_overrun,
    output logic              busy
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic              brk_det
`endif
);

    localparam int              OS_W      = $clog2(OS_RATE);
    localparam logic [OS_W-1:0] SMP_A     = OS_W'(SAMPLE_MID - 2);
    localparam logic [OS_W-1:0] SMP_B     = OS_W'(SAMPLE_MID - 1);
    localparam logic [OS_W-1:0] SMP_DEC   = OS_W'(SAMPLE_MID);
    localparam logic [OS_W-1:0] BIT_END   = OS_W'(OS_RATE - 1);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_W - 1);

    logic              rx_meta, rx_s;
    state_t            state;
    logic [OS_W-1:0]   os_cnt;
    logic [3:0]        bit_cnt;
    logic [1:0]        smp;
    logic [DATA_W-1:0] shreg;
    logic [DIV_W-1:0]  div_q, tick_div;
    parity_e           par_q;
    logic              stop2_q, stop_idx, stop_err_q, par_bit_q;
    logic              tick, start_det, maj, at_dec, at_end, last_stop;
    logic              complete, frame_err, par_err, brk, deliver, overrun;

    // NOTE: synchroniser flops reset to the idle line level (1) so leaving
    // reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Free-runs on the live divisor while idle; locked to the frame's divisor after.
    assign start_det = (state == ST_IDLE) && !rx_s;
    assign tick_div  = (state == ST_IDLE) ? cfg_div : div_q;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .div     (tick_div),
        .rephase (start_det),
        .tick    (tick)
    );

    assign maj       = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);
    assign at_dec    = tick && (os_cnt == SMP_DEC);
    assign at_end    = tick && (os_cnt == BIT_END);
    assign last_stop = !stop2_q || stop_idx;
    assign complete  = (state == ST_STOP) && at_dec && last_stop;
    assign frame_err = stop_err_q | ~maj;
    assign par_err   = (par_q != PAR_NONE) &&
                       (((^shreg) ^ par_bit_q) != (par_q == PAR_ODD));

`ifdef UART_RX_BREAK_DET_EN
    assign brk = complete && (shreg == '0) && !maj &&
                 ((par_q == PAR_NONE) || !par_bit_q);
`else
    assign brk = 1'b0;
`endif

    assign deliver = complete && !brk && (!rx_valid || rx_ready);
    assign overrun = complete && !brk && rx_valid && !rx_ready;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            smp        <= 2'b11;
            shreg      <= '0;
            div_q      <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx   <= 1'b0;
            stop_err_q <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state      <= ST_START;
                        os_cnt     <= '0;
                        bit_cnt    <= '0;
                        div_q      <= cfg_div;
                        par_q      <= decode_parity(cfg_parity);
                        stop2_q    <= cfg_stop2;
                        stop_idx   <= 1'b0;
                        stop_err_q <= 1'b0;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) state <= ST_IDLE;
                end
                ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                    if (tick) begin
                        os_cnt <= os_cnt + OS_W'(1);
                        if (os_cnt == SMP_A) smp[1] <= rx_s;
                        if (os_cnt == SMP_B) smp[0] <= rx_s;
                        case (state)
                            ST_START: begin
                                if (at_dec && maj) state <= ST_IDLE;
                                else if (at_end)   state <= ST_DATA;
                            end
                            ST_DATA: begin
                                if (at_dec) shreg <= {maj, shreg[DATA_W-1:1]};
                                if (at_end) begin
                                    if (bit_cnt == LAST_DATA) begin
                                        bit_cnt <= '0;
                                        state   <= (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                                    end else begin
                                        bit_cnt <= bit_cnt + 4'd1;
                                    end
                                end
                            end
                            ST_PARITY: begin
                                if (at_dec) par_bit_q <= maj;
                                if (at_end) state <= ST_STOP;
                            end
                            ST_STOP: begin
                                // Completing mid-bit re-arms the receiver half a bit early.
                                if (complete) begin
                                    state <= frame_err ? ST_WAIT_IDLE : ST_IDLE;
                                end else begin
                                    if (at_dec) stop_err_q <= stop_err_q | ~maj;
                                    if (at_end) stop_idx <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= overrun;
            if (deliver) begin
                rx_data    <= shreg;
                err_frame  <= frame_err;
                err_parity <= par_err;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) brk_det <= 1'b0;
        else        brk_det <= brk;
    end
`endif

endmodule
